// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_srca,
  input  logic [DATA_W-1:0] i_req0_srcb,
  input  logic [3:0]        i_req0_ctrl,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_srca,
  input  logic [DATA_W-1:0] i_req1_srcb,
  input  logic [3:0]        i_req1_ctrl,
  output logic [DATA_W-1:0] o_alu_srca,
  output logic [DATA_W-1:0] o_alu_srcb,
  output logic [3:0]        o_alu_ctrl,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_zero,
  input  logic              i_alu_slt,
  input  logic              i_alu_ult,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic              o_rsp_zero,
  output logic              o_rsp_slt,
  output logic              o_rsp_ult
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W-1:0]   r_rsp_result;
  logic                r_rsp_zero;
  logic                r_rsp_slt;
  logic                r_rsp_ult;

  logic                w_grant;
  logic                w_grant_idx;

  // Grant decision: only in IDLE and outside reset; on contention favour the requester not served last
  always_comb begin
    w_grant     = (r_state == S_IDLE) && !i_rst && (i_req0_valid || i_req1_valid);
    w_grant_idx = (i_req0_valid && i_req1_valid) ? ~r_last_grant : i_req1_valid;
  end

  // Ready and ALU operand steering follow the grant; the ALU sees zeros when nobody owns it
  always_comb begin
    o_req0_ready = w_grant && !w_grant_idx;
    o_req1_ready = w_grant &&  w_grant_idx;
    o_alu_srca   = '0;
    o_alu_srcb   = '0;
    o_alu_ctrl   = '0;
    if (w_grant) begin
      if (w_grant_idx) begin
        o_alu_srca = i_req1_srca;
        o_alu_srcb = i_req1_srcb;
        o_alu_ctrl = i_req1_ctrl;
      end else begin
        o_alu_srca = i_req0_srca;
        o_alu_srcb = i_req0_srcb;
        o_alu_ctrl = i_req0_ctrl;
      end
    end
  end

  // Two-state controller: capture the ALU outcome on accept, hold it until the consumer takes it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_slt    <= 1'b0;
      r_rsp_ult    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_last_grant <= w_grant_idx;
            r_rsp_id     <= w_grant_idx;
            r_rsp_result <= i_alu_result;
            r_rsp_zero   <= i_alu_zero;
            r_rsp_slt    <= i_alu_slt;
            r_rsp_ult    <= i_alu_ult;
            r_rsp_valid  <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_rsp_valid && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_zero   = r_rsp_zero;
  assign o_rsp_slt    = r_rsp_slt;
  assign o_rsp_ult    = r_rsp_ult;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; SHALL be fixed at 32 in this core.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_srca, req0_srcb  in  32 each  requester 0 operands.
REQ-007 req0_ctrl  in  4  requester 0 ALU op code.
REQ-008 req1_valid, req1_ready, req1_srca, req1_srcb, req1_ctrl: same directions, widths and meanings for requester 1.
REQ-009 alu_srca, alu_srcb  out  32 each  operands driven to the shared ALU.
REQ-010 alu_ctrl  out  4  op code driven to the shared ALU.
REQ-011 alu_result  in  32  combinational ALU result.
REQ-012 alu_zero, alu_slt, alu_ult  in  1 each  ALU zero, signed-less and unsigned-less flags.
REQ-013 rsp_valid  out  1  registered response available.
REQ-014 rsp_ready  in  1  consumer accepts the response.
REQ-015 rsp_id  out  1  requester that owns the response (0 or 1).
REQ-016 rsp_result  out  32  captured alu_result.
REQ-017 rsp_zero, rsp_slt, rsp_ult  out  1 each  captured ALU flags.

Function
REQ-018 The block SHALL have two states: IDLE (can accept) and RESP (holding a response).
REQ-019 In IDLE with at least one reqN_valid high, the block SHALL grant exactly one requester, assert its reqN_ready combinationally, and drive its srca/srcb/ctrl onto alu_*.
REQ-020 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it.
REQ-021 A last_grant register SHALL update only on an accepting cycle.
REQ-022 On the accepting edge, the block SHALL capture alu_result and the three flags into the rsp_* registers, set rsp_id to the granted index, set rsp_valid=1, and move to RESP.
REQ-023 Latency SHALL be one cycle: accept in cycle N -> rsp_valid=1 in cycle N+1.
REQ-024 In RESP, both reqN_ready SHALL be 0 and rsp_* SHALL stay stable until rsp_valid&&rsp_ready.
REQ-025 On rsp_valid&&rsp_ready, the block SHALL clear rsp_valid and return to IDLE; no new accept occurs in that cycle. Sustained throughput is one operation per two cycles.
REQ-026 When no grant is active (IDLE with no valid, or RESP), alu_srca, alu_srcb and alu_ctrl SHALL be driven to 0.
REQ-027 Requesters SHALL hold valid and operands stable until ready. The arbiter SHALL NOT drop or duplicate an accepted operation.
REQ-028 reqN_ready SHALL never be high for both requesters in the same cycle, and never high while reqN_valid is low.
REQ-029 Starvation: with both requesters continuously valid, grants SHALL strictly alternate 0,1,0,1...
REQ-030 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-031 While rst=1, regardless of clk: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=rsp_slt=rsp_ult=0, last_grant=1 (requester 0 wins the first contention).
REQ-032 Reset asserted mid-operation SHALL discard any held response without handshake. After deassertion, the first accept SHALL occur no earlier than the first rising edge with rst=0.

Verification
REQ-033 Single op: req0 srca=5, srcb=3, ctrl=0000, ALU model adds -> req0_ready=1 in cycle N; cycle N+1 rsp_valid=1, rsp_id=0, rsp_result=8.
REQ-034 Contention after reset: both valid in same cycle -> req0 granted first; after response handshake, req1 granted next; rsp_id sequence 0,1.
REQ-035 Back-pressure: rsp_ready=0 for 5 cycles with req1 valid -> rsp_* unchanged, req1_ready=0 throughout; req1 accepted only in the cycle after the handshake.
REQ-036 Flags: req1 srca=7, srcb=7, ctrl=0001 -> rsp_result=0, rsp_zero=1, rsp_id=1; srca=0xFFFFFFFF, srcb=1 -> rsp_slt=1, rsp_ult=0.
REQ-037 Reset mid-RESP: rsp_valid=1, rst pulsed asynchronously between edges -> rsp_valid=0 immediately, alu_* all 0, next contention grants req0.
REQ-038 Fairness soak: both valid for 20 operations with rsp_ready=1 -> grants alternate 0,1 exactly, 20 responses, no ready overlap.
